// File: rtl/link_pkg.sv
// Shared types and defaults for the bit-serial Arduino link.
package link_pkg;
    localparam int LINK_WORD_W  = 16;
    localparam int LINK_TIMEOUT = 255;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_SHIFT,
        TX_DONE
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no flow control.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/serial_link.sv
// Full-duplex bit-serial transceiver: 2 clk/bit TX (waits on ard_rdy), strobe-sampled RX with idle timeout.
// SERIAL_LINK_PARITY_EN appends an even-parity bit to frames in both directions.
module serial_link
    import link_pkg::*;
#(
    parameter int WORD_W  = LINK_WORD_W,
    parameter int TIMEOUT = LINK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [WORD_W-1:0] tx_word,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    input  logic              ard_rdy,
    output logic              ser_out,
    output logic              ser_clk_out,
    input  logic              ser_in,
    input  logic              ser_clk_in,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    output logic              error
);
`ifdef SERIAL_LINK_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    localparam int CNT_W  = $clog2(FRAME_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // ---------------- TX ----------------
    tx_state_t          tx_state, tx_state_nx;
    logic [FRAME_W-1:0] tx_sr, tx_sr_nx;
    logic [CNT_W-1:0]   tx_cnt, tx_cnt_nx;
    logic               tx_phase, tx_phase_nx;
    logic [FRAME_W-1:0] tx_frame;

`ifdef SERIAL_LINK_PARITY_EN
    assign tx_frame = {tx_word, ^tx_word};
`else
    assign tx_frame = tx_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_sr    <= '0;
            tx_cnt   <= '0;
            tx_phase <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_sr    <= tx_sr_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_phase <= tx_phase_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_sr_nx    = tx_sr;
        tx_cnt_nx   = tx_cnt;
        tx_phase_nx = tx_phase;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_sr_nx    = tx_frame;
                    tx_cnt_nx   = '0;
                    tx_phase_nx = 1'b0;
                    tx_state_nx = ard_rdy ? TX_SHIFT : TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (ard_rdy) begin
                    tx_state_nx = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                // Phase 1 is the strobe-high half; the bit advances as it ends.
                tx_phase_nx = ~tx_phase;
                if (tx_phase) begin
                    tx_sr_nx = {tx_sr[FRAME_W-2:0], 1'b0};
                    if (tx_cnt == CNT_W'(FRAME_W - 1)) begin
                        tx_cnt_nx   = '0;
                        tx_state_nx = TX_DONE;
                    end else begin
                        tx_cnt_nx = tx_cnt + CNT_W'(1);
                    end
                end
            end
            TX_DONE: tx_state_nx = TX_IDLE;
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    assign ser_out     = (tx_state == TX_SHIFT) & tx_sr[FRAME_W-1];
    assign ser_clk_out = (tx_state == TX_SHIFT) & tx_phase;
    assign tx_busy     = (tx_state == TX_WAIT) | (tx_state == TX_SHIFT);
    assign tx_done     = (tx_state == TX_DONE);
    assign tx_ready    = (tx_state == TX_IDLE) & ard_rdy;

    // ---------------- RX ----------------
    logic s_dat, s_clk;
    logic strobe_d, strobe_dd, dat_d;
    logic strobe_rise, strobe_edge;

    sync2 u_sync_dat (.clk(clk), .rst(rst), .d(ser_in),     .q(s_dat));
    sync2 u_sync_clk (.clk(clk), .rst(rst), .d(ser_clk_in), .q(s_clk));

    // One more stage keeps data aligned with the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_d  <= 1'b0;
            strobe_dd <= 1'b0;
            dat_d     <= 1'b0;
        end else begin
            strobe_d  <= s_clk;
            strobe_dd <= strobe_d;
            dat_d     <= s_dat;
        end
    end

    assign strobe_rise = strobe_d & ~strobe_dd;
    assign strobe_edge = strobe_d ^ strobe_dd;

    rx_state_t          rx_state, rx_state_nx;
    logic [FRAME_W-2:0] rx_sr, rx_sr_nx;
    logic [FRAME_W-1:0] rx_shift;
    logic [CNT_W-1:0]   rx_cnt, rx_cnt_nx;
    logic [IDLE_W-1:0]  rx_idle, rx_idle_nx;
    logic [WORD_W-1:0]  rx_word_nx;
    logic               rx_valid_nx, error_nx;

    assign rx_shift = {rx_sr, dat_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_sr    <= '0;
            rx_cnt   <= '0;
            rx_idle  <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
            error    <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_sr    <= rx_sr_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idle  <= rx_idle_nx;
            rx_word  <= rx_word_nx;
            rx_valid <= rx_valid_nx;
            error    <= error_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_sr_nx    = rx_sr;
        rx_cnt_nx   = rx_cnt;
        rx_idle_nx  = rx_idle;
        rx_word_nx  = rx_word;
        rx_valid_nx = 1'b0;
        error_nx    = 1'b0;
        if (strobe_rise) begin
            rx_sr_nx   = rx_shift[FRAME_W-2:0];
            rx_idle_nx = '0;
            if (rx_cnt == CNT_W'(FRAME_W - 1)) begin
                rx_cnt_nx   = '0;
                rx_state_nx = RX_IDLE;
`ifdef SERIAL_LINK_PARITY_EN
                if (^rx_shift) begin
                    error_nx = 1'b1;
                end else begin
                    rx_word_nx  = rx_shift[FRAME_W-1:1];
                    rx_valid_nx = 1'b1;
                end
`else
                rx_word_nx  = rx_shift;
                rx_valid_nx = 1'b1;
`endif
            end else begin
                rx_cnt_nx   = rx_cnt + CNT_W'(1);
                rx_state_nx = RX_SHIFT;
            end
        end else if (rx_state == RX_SHIFT) begin
            if (strobe_edge) begin
                rx_idle_nx = '0;
            end else if (rx_idle == IDLE_W'(TIMEOUT - 1)) begin
                // Abandon the partial frame; rx_word keeps the last good word.
                error_nx    = 1'b1;
                rx_cnt_nx   = '0;
                rx_idle_nx  = '0;
                rx_state_nx = RX_IDLE;
            end else begin
                rx_idle_nx = rx_idle + IDLE_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_serial_link.sv
// Randomized scoreboard bench for serial_link: TX frames and RX words checked by free-running monitors.
module tb_serial_link;
    localparam int W       = 16;
    localparam int TIMEOUT = 255;
`ifdef SERIAL_LINK_PARITY_EN
    localparam int BITS = W + 1;
`else
    localparam int BITS = W;
`endif

    logic         clk = 1'b0;
    logic         rst, tx_start, ard_rdy, ser_in, ser_clk_in;
    logic [W-1:0] tx_word;
    logic         tx_ready, tx_busy, tx_done, ser_out, ser_clk_out, rx_valid, error;
    logic [W-1:0] rx_word;

    serial_link dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_word(tx_word),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
        .ard_rdy(ard_rdy), .ser_out(ser_out), .ser_clk_out(ser_clk_out),
        .ser_in(ser_in), .ser_clk_in(ser_clk_in), .rx_word(rx_word),
        .rx_valid(rx_valid), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: word MSB first, optionally followed by its even-parity bit.
    function automatic logic [31:0] frame_of(input logic [W-1:0] w);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(w[i]);
`ifdef SERIAL_LINK_PARITY_EN
        return (32'(w) << 1) | 32'(ones % 2);
`else
        return 32'(w) + 32'(ones * 0);
`endif
    endfunction

    logic [31:0] tx_exp_q[$];
    int          tx_cyc_q[$];
    logic [W-1:0] rx_exp_q[$];
    int          rx_cyc_q[$];
    int          err_seen = 0;
    int          err_exp = 0;
    int          last_err_cyc = 0;

    // TX monitor: collect ser_out at each strobe rise, score on tx_done.
    logic [31:0] mon_val = 0;
    int          mon_n = 0;
    int          first_strobe = 0;
    logic        prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mon_val = 0;
            mon_n = 0;
            prev_sclk = 1'b0;
        end else begin
            if (ser_clk_out && !prev_sclk) begin
                if (mon_n == 0) first_strobe = cyc;
                mon_val = (mon_val << 1) | 32'(ser_out);
                mon_n++;
                check("strobe_implies_busy", 32'(tx_busy), 32'd1);
            end
            prev_sclk = ser_clk_out;
            if (tx_done) begin
                if (tx_exp_q.size() == 0 || tx_cyc_q.size() == 0) begin
                    check("tx_unexpected_done", 32'(tx_done), 32'd0);
                end else begin
                    logic [31:0] ef;
                    int ec;
                    ef = tx_exp_q.pop_front();
                    ec = tx_cyc_q.pop_front();
                    check("tx_frame", mon_val, ef);
                    check("tx_bit_count", 32'(mon_n), 32'(BITS));
                    check("tx_done_cycle", 32'(cyc), 32'(ec));
                    check("tx_first_strobe", 32'(first_strobe), 32'(ec - 2*BITS + 1));
                    check("tx_busy_at_done", 32'(tx_busy), 32'd0);
                end
                mon_val = 0;
                mon_n = 0;
            end
        end
    end

    // RX monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (rx_exp_q.size() == 0 || rx_cyc_q.size() == 0) begin
                    check("rx_unexpected_valid", 32'(rx_valid), 32'd0);
                end else begin
                    check("rx_word", 32'(rx_word), 32'(rx_exp_q.pop_front()));
                    check("rx_valid_cycle", 32'(cyc), 32'(rx_cyc_q.pop_front()));
                end
            end
            if (error) begin
                err_seen++;
                last_err_cyc = cyc;
            end
        end
    end

    task automatic exp_tx(input logic [W-1:0] w, input int shift_start);
        tx_exp_q.push_back(frame_of(w));
        tx_cyc_q.push_back(shift_start + 2*BITS);
    endtask

    task automatic tx_send(input logic [W-1:0] w);
        tx_word  = w;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (!tx_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_done_within_bound", 32'(n < 200), 32'd1);
        @(negedge clk);
    endtask

    // Strobe: 3 cycles low with data set, then 3 cycles high.
    task automatic rx_send_bits(input logic [31:0] val, input int nbits, input bit track);
        for (int i = nbits - 1; i >= 0; i--) begin
            ser_in = val[i];
            ser_clk_in = 1'b0;
            repeat (3) @(negedge clk);
            ser_clk_in = 1'b1;
            if (track && i == 0) rx_cyc_q.push_back(cyc + 4);
            repeat (3) @(negedge clk);
        end
        ser_clk_in = 1'b0;
        ser_in = 1'b0;
    endtask

    task automatic rx_frame(input logic [W-1:0] w);
        rx_exp_q.push_back(w);
        rx_send_bits(frame_of(w), BITS, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w, w2, last_rx;
        int f, e0;

        rst = 1'b1; tx_start = 1'b0; tx_word = '0; ard_rdy = 1'b1;
        ser_in = 1'b0; ser_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_ser_clk_out", 32'(ser_clk_out), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rx_word", 32'(rx_word), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx_ready", 32'(tx_ready), 32'd1);

        // Directed TX
        exp_tx(16'hA5C3, cyc + 1);
        tx_send(16'hA5C3);
        check("tx_busy_after_start", 32'(tx_busy), 32'd1);
        check("tx_ready_while_busy", 32'(tx_ready), 32'd0);
        wait_tx_done();

        // TX held off by ard_rdy, with ignored starts in WAIT and mid-frame
        ard_rdy = 1'b0;
        @(negedge clk);
        check("tx_ready_no_ard", 32'(tx_ready), 32'd0);
        tx_exp_q.push_back(frame_of(16'h0001));
        tx_send(16'h0001);
        for (int i = 0; i < 10; i++) begin
            check("wait_busy", 32'(tx_busy), 32'd1);
            check("wait_no_strobe", 32'(ser_clk_out), 32'd0);
            if (i == 4) tx_send(16'hFFFF);
            else @(negedge clk);
        end
        ard_rdy = 1'b1;
        tx_cyc_q.push_back(cyc + 1 + 2*BITS);
        repeat (6) @(negedge clk);
        tx_send(16'h5555);
        wait_tx_done();
        repeat (40) @(negedge clk);

        // Random TX, some with ard_rdy dropping mid-frame
        for (int i = 0; i < 6; i++) begin
            w = W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp_tx(w, cyc + 1);
            tx_send(w);
            if (i % 2 == 1) begin
                repeat (5) @(negedge clk);
                ard_rdy = 1'b0;
                repeat (4) @(negedge clk);
                ard_rdy = 1'b1;
            end
            wait_tx_done();
        end

        // Directed and random RX
        rx_frame(16'h1234);
        repeat (30) @(negedge clk);
        check("rx_word_held", 32'(rx_word), 32'h1234);
        last_rx = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            w = W'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            rx_frame(w);
            last_rx = w;
        end

        // Timeout on a 5-bit partial frame
        w = W'($urandom);
        e0 = err_seen;
        rx_send_bits(32'(w), 5, 1'b0);
        f = cyc;
        err_exp++;
        repeat (TIMEOUT + 20) @(negedge clk);
        check("timeout_error_count", 32'(err_seen - e0), 32'd1);
        check("timeout_not_early", 32'(last_err_cyc >= f + TIMEOUT), 32'd1);
        check("timeout_not_late", 32'(last_err_cyc <= f + TIMEOUT + 8), 32'd1);
        check("timeout_rx_word_kept", 32'(rx_word), 32'(last_rx));
        rx_frame(16'hBEEF);

        // Full duplex, both complete
        w = W'($urandom);
        w2 = W'($urandom);
        fork
            begin
                exp_tx(w, cyc + 1);
                tx_send(w);
                wait_tx_done();
            end
            rx_frame(w2);
        join

        // Full duplex aborted by reset
        tx_send(16'hFFFF);
        rx_send_bits(32'h0F0F >> 12, 4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_busy", 32'(tx_busy), 32'd0);
        check("abort_tx_done", 32'(tx_done), 32'd0);
        check("abort_ser_out", 32'(ser_out), 32'd0);
        check("abort_ser_clk_out", 32'(ser_clk_out), 32'd0);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_rx_word", 32'(rx_word), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e0 = err_seen;
        repeat (300) @(negedge clk);
        check("post_reset_no_error", 32'(err_seen - e0), 32'd0);
        check("post_reset_tx_ready", 32'(tx_ready), 32'd1);

`ifdef SERIAL_LINK_PARITY_EN
        // 16'h0003 has even parity 0; sending 1 must be rejected
        e0 = err_seen;
        rx_send_bits(32'h0000_0007, BITS, 1'b0);
        err_exp++;
        repeat (8) @(negedge clk);
        check("parity_error_count", 32'(err_seen - e0), 32'd1);
        check("parity_rx_word_kept", 32'(rx_word), 32'd0);
        exp_tx(16'h0001, cyc + 1);
        tx_send(16'h0001);
        wait_tx_done();
`endif

        repeat (20) @(negedge clk);
        check("error_total", 32'(err_seen), 32'(err_exp));
        check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
